mem_bus_xbar: RTL and testbench

- Parametrised successor to the fixed CPU/HCI memory mux at the top level.
- Arbitrates NUM_MASTERS byte-wide bus masters onto one RAM port and one memory-mapped I/O port (hci io interface).
- Decodes address into RAM or I/O region and issues one transaction per cycle.
- Steers read data back through registered return tags; stalls I/O writes on io_full.

---
 rtl/mem_bus_xbar.sv | 108 ++++++++++
 tb/tb_mem_bus_xbar.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_xbar.sv
// mem_bus_xbar: arbitrates byte-wide masters onto a RAM port and an I/O port, with registered read return.
// Define MEM_BUS_XBAR_RR_ARB_EN for round-robin arbitration instead of fixed priority.
module mem_bus_xbar #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int DATA_WIDTH     = 8,
   parameter int IO_SEL_WIDTH   = 3
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic [NUM_MASTERS-1:0]            m_req_in,
   input  logic [NUM_MASTERS-1:0]            m_wr_in,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_in,
   output logic [NUM_MASTERS-1:0]            m_gnt_out,
   output logic [NUM_MASTERS-1:0]            m_rvalid_out,
   output logic [DATA_WIDTH-1:0]             m_rdata_out,
   output logic                              ram_en_out,
   output logic                              ram_r_nw_out,
   output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
   output logic [DATA_WIDTH-1:0]             ram_d_out,
   input  logic [DATA_WIDTH-1:0]             ram_d_in,
   output logic                              io_en_out,
   output logic                              io_wr_out,
   output logic [IO_SEL_WIDTH-1:0]           io_sel_out,
   output logic [DATA_WIDTH-1:0]             io_d_out,
   input  logic [DATA_WIDTH-1:0]             io_d_in,
   input  logic                              io_full_in
);
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   logic [NUM_MASTERS-1:0]    elig;
   logic [IW-1:0]             win, ret_master;
   logic                      hit, sel_wr, sel_io, ret_valid, ret_is_io;
   logic [RAM_ADDR_WIDTH:0]   sel_a;
   logic [DATA_WIDTH-1:0]     sel_d, d_q, rdata_q;
   logic [RAM_ADDR_WIDTH-1:0] a_q;
   logic [IO_SEL_WIDTH-1:0]   s_q;
`ifdef MEM_BUS_XBAR_RR_ARB_EN
   logic [IW-1:0]             ptr;
`endif
   // I/O writes are masked while the I/O buffer is full so a lower-priority master can use the cycle
   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_elig
      assign elig[g] = rst_n_in & m_req_in[g] &
         ~(m_wr_in[g] & io_full_in & (m_a_in[g*ADDR_WIDTH+RAM_ADDR_WIDTH -: 2] == 2'b11));
   end
   always_comb begin
      win = '0;
      hit = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
`ifdef MEM_BUS_XBAR_RR_ARB_EN
         if (!hit && elig[(int'(ptr) + k) % NUM_MASTERS]) begin
            hit = 1'b1;
            win = IW'((int'(ptr) + k) % NUM_MASTERS);
         end
`else
         if (!hit && elig[k]) begin
            hit = 1'b1;
            win = IW'(k);
         end
`endif
      end
   end
   assign sel_a  = m_a_in[int'(win)*ADDR_WIDTH +: RAM_ADDR_WIDTH+1];
   assign sel_d  = m_wdata_in[int'(win)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_wr = m_wr_in[win];
   assign sel_io = sel_a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11;
   assign m_gnt_out    = hit ? (NUM_MASTERS'(1) << win) : '0;
   assign ram_en_out   = hit & ~sel_io;
   assign ram_r_nw_out = ~(hit & ~sel_io & sel_wr);
   assign io_en_out    = hit & sel_io;
   assign io_wr_out    = hit & sel_io & sel_wr;
   assign ram_a_out    = hit ? sel_a[RAM_ADDR_WIDTH-1:0] : a_q;
   assign io_sel_out   = hit ? sel_a[IO_SEL_WIDTH-1:0] : s_q;
   assign ram_d_out    = hit ? sel_d : d_q;
   assign io_d_out     = hit ? sel_d : d_q;
   assign m_rvalid_out = ret_valid ? (NUM_MASTERS'(1) << ret_master) : '0;
   assign m_rdata_out  = ret_valid ? (ret_is_io ? io_d_in : ram_d_in) : rdata_q;
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         a_q        <= '0;
         s_q        <= '0;
         d_q        <= '0;
         rdata_q    <= '0;
         ret_valid  <= 1'b0;
         ret_master <= '0;
         ret_is_io  <= 1'b0;
      end else begin
         if (hit) begin
            a_q <= sel_a[RAM_ADDR_WIDTH-1:0];
            s_q <= sel_a[IO_SEL_WIDTH-1:0];
            d_q <= sel_d;
         end
         ret_valid <= hit & ~sel_wr;
         if (hit && !sel_wr) begin
            ret_master <= win;
            ret_is_io  <= sel_io;
         end
         if (ret_valid) rdata_q <= m_rdata_out;
      end
   end
`ifdef MEM_BUS_XBAR_RR_ARB_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) ptr <= '0;
      else if (hit) ptr <= (int'(win) == NUM_MASTERS-1) ? '0 : win + 1'b1;
   end
`endif
endmodule

// File: tb/tb_mem_bus_xbar.sv
// tb_mem_bus_xbar: directed checks of arbitration, decode, read return, io_full skipping and reset.
module tb_mem_bus_xbar;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  m_req, m_wr, m_gnt, m_rvalid;
   logic [63:0] m_a;
   logic [15:0] m_wd;
   logic [7:0]  m_rdata, ram_d, ram_q, io_d, io_dout;
   logic        ram_en, ram_r_nw, io_en, io_wr, io_full;
   logic [16:0] ram_a;
   logic [2:0]  io_sel;
   logic [7:0]  mem [0:255];
   int checks = 0;
   int errors = 0;

   mem_bus_xbar dut (
      .clk_in(clk), .rst_n_in(rst_n), .m_req_in(m_req), .m_wr_in(m_wr), .m_a_in(m_a),
      .m_wdata_in(m_wd), .m_gnt_out(m_gnt), .m_rvalid_out(m_rvalid), .m_rdata_out(m_rdata),
      .ram_en_out(ram_en), .ram_r_nw_out(ram_r_nw), .ram_a_out(ram_a), .ram_d_out(ram_d),
      .ram_d_in(ram_q), .io_en_out(io_en), .io_wr_out(io_wr), .io_sel_out(io_sel),
      .io_d_out(io_dout), .io_d_in(io_d), .io_full_in(io_full)
   );

   always #5 clk = ~clk;

   // small synchronous RAM, read data one cycle after enable
   always @(posedge clk) begin
      if (ram_en) begin
         if (!ram_r_nw) mem[ram_a[7:0]] <= ram_d;
         ram_q <= mem[ram_a[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] wr, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [7:0] d0, input logic [7:0] d1);
      m_req = req;
      m_wr  = wr;
      m_a   = {a1, a0};
      m_wd  = {d1, d0};
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ram_q   = 8'h00;
      rst_n   = 1'b0;
      io_full = 1'b0;
      io_d    = 8'h00;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", m_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_io_en", io_en, 0);
      chk("rst_io_wr", io_wr, 0);
      chk("rst_r_nw", ram_r_nw, 1);
      chk("rst_rvalid", m_rvalid, 0);
      chk("rst_rdata", m_rdata, 0);
      chk("rst_ram_a", ram_a, 0);
      rst_n = 1'b1;
      // single master RAM write then read
      drive(2'b01, 2'b01, 32'h10, 0, 8'hA5, 0);
      chk("wr_gnt", m_gnt, 2'b01);
      chk("wr_ram_en", ram_en, 1);
      chk("wr_r_nw", ram_r_nw, 0);
      chk("wr_ram_a", ram_a, 17'h10);
      chk("wr_ram_d", ram_d, 8'hA5);
      chk("wr_io_en", io_en, 0);
      step;
      drive(2'b01, 2'b00, 32'h10, 0, 0, 0);
      chk("rd_gnt", m_gnt, 2'b01);
      chk("rd_r_nw", ram_r_nw, 1);
      chk("wr_no_rvalid", m_rvalid, 0);
      step;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      chk("rd_rvalid", m_rvalid, 2'b01);
      chk("rd_rdata", m_rdata, 8'hA5);
      chk("idle_ram_en", ram_en, 0);
      chk("idle_r_nw", ram_r_nw, 1);
      chk("idle_hold_a", ram_a, 17'h10);
      step;
      chk("hold_rvalid", m_rvalid, 0);
      chk("hold_rdata", m_rdata, 8'hA5);
`ifdef MEM_BUS_XBAR_RR_ARB_EN
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive(2'b11, 2'b00, 32'h1, 32'h2, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("rr_gnt", m_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
         step;
      end
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      step;
`else
      drive(2'b11, 2'b00, 32'h1, 32'h2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("prio_gnt", m_gnt, 2'b01);
         if (i > 0) chk("prio_rvalid", m_rvalid, 2'b01);
         step;
      end
      drive(2'b10, 2'b00, 32'h1, 32'h2, 0, 0);
      chk("m1_gnt", m_gnt, 2'b10);
      chk("m1_ram_a", ram_a, 17'h2);
      chk("m0_last_rvalid", m_rvalid, 2'b01);
      step;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      chk("m1_rvalid", m_rvalid, 2'b10);
      step;
`endif
      // I/O decode and return
      io_d = 8'h3C;
      drive(2'b10, 2'b00, 0, 32'h0003_0004, 0, 0);
      chk("io_gnt", m_gnt, 2'b10);
      chk("io_en", io_en, 1);
      chk("io_sel", io_sel, 3'd4);
      chk("io_ram_en", ram_en, 0);
      chk("io_wr", io_wr, 0);
      step;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      chk("io_rvalid", m_rvalid, 2'b10);
      chk("io_rdata", m_rdata, 8'h3C);
      step;
      // decode boundaries
      drive(2'b01, 2'b00, 32'h0002_FFFF, 0, 0, 0);
      chk("b_ram_en", ram_en, 1);
      chk("b_io_en", io_en, 0);
      chk("b_ram_a", ram_a, 17'h0FFFF);
      drive(2'b01, 2'b00, 32'hFFF3_0000, 0, 0, 0);
      chk("b_hi_io_en", io_en, 1);
      chk("b_hi_ram_en", ram_en, 0);
      chk("b_hi_sel", io_sel, 0);
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      step;
      // io_full skip
      io_full = 1'b1;
      drive(2'b11, 2'b01, 32'h0003_0000, 32'h20, 8'h77, 0);
      chk("full_gnt", m_gnt, 2'b10);
      chk("full_ram_en", ram_en, 1);
      chk("full_io_en", io_en, 0);
      step;
      io_full = 1'b0;
      drive(2'b01, 2'b01, 32'h0003_0000, 32'h20, 8'h77, 0);
      chk("unfull_gnt", m_gnt, 2'b01);
      chk("unfull_io_wr", io_wr, 1);
      chk("unfull_io_d", io_dout, 8'h77);
      chk("unfull_sel", io_sel, 0);
      chk("unfull_rvalid", m_rvalid, 2'b10);
      step;
      io_full = 1'b1;
      drive(2'b01, 2'b01, 32'h0003_0000, 0, 8'h77, 0);
      chk("blk_gnt", m_gnt, 0);
      chk("blk_en", {ram_en, io_en}, 0);
      drive(2'b11, 2'b01, 32'h0003_0000, 32'h0003_0005, 8'h77, 0);
      chk("full_rd_gnt", m_gnt, 2'b10);
      chk("full_rd_io_en", io_en, 1);
      chk("full_rd_io_wr", io_wr, 0);
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      io_full = 1'b0;
      step;
      // back-to-back alternating RAM / I/O reads
      io_d = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, 2'b00, (i % 2 == 1) ? 32'h0003_0001 : 32'h10, 0, 0, 0);
         if (i > 0) begin
            chk("bb_rvalid", m_rvalid, 2'b01);
            chk("bb_rdata", m_rdata, (i % 2 == 1) ? 8'hA5 : 8'h5A);
         end
         step;
      end
      // reset right after a read grant drops the return
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rvalid", m_rvalid, 0);
      chk("mid_rst_gnt", m_gnt, 0);
      chk("mid_rst_rdata", m_rdata, 0);
      step;
      rst_n = 1'b1;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      chk("post_rst_rvalid", m_rvalid, 0);
      step;
      chk("post_rst_rvalid2", m_rvalid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
